// File: rtl/filt_iir_inv_mac.sv
// filt_iir_inv_mac
//   Inverse (equalising) IIR filter, y[n] = (B(z)/A(z)) x[n], built around a single
//   time-multiplexed multiply-accumulate. Programming A with a forward filter's
//   numerator undoes that filter. One feed-forward tap per cycle, then one feedback
//   tap per cycle, then the result is held until the sink takes it.
//
//   Ports
//     i_clk, i_rst      clock (rising edge), asynchronous active-high reset
//     i_ena             clock enable; low freezes all state and gates o_ready/o_valid
//     i_num_coeff       b_k packed at [k*gp_coeff_width +: gp_coeff_width]
//     i_den_coeff       a_k, same packing; a0 is implied as 2^gp_frac_bits
//     i_data, i_valid   input sample and its valid; accepted when o_ready is high
//     o_ready           high only in IDLE
//     o_data, o_valid   reconstructed sample, held until i_ready
//     i_ready           sink accepts o_data
//     o_sat             o_data was clipped (saturating build only, else tied 0)
//
//   Build option
//     FILT_IIR_INV_SAT_EN  defined: saturate the output and report clipping on o_sat.
//                          undefined: keep the low gp_oup_width bits (wrap).
//
//   state  | meaning
//   IDLE   | waiting for an input sample, o_ready high
//   MAC_FF | acc += b[tap]*x[tap], tap = 0..Nb-1
//   MAC_FB | acc -= a[tap]*y[tap-1], tap = 1..Na-1
//   OUT    | o_data/o_valid held until i_ready
module filt_iir_inv_mac #(
    parameter int gp_inp_width        = 16,
    parameter int gp_oup_width        = 8,
    parameter int gp_num_coeff_length = 3,
    parameter int gp_den_coeff_length = 3,
    parameter int gp_coeff_width      = 8,
    parameter int gp_frac_bits        = 6
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst,
    input  logic                                             i_ena,
    input  logic [gp_coeff_width*gp_num_coeff_length-1:0]    i_num_coeff,
    input  logic [gp_coeff_width*gp_den_coeff_length-1:0]    i_den_coeff,
    input  logic signed [gp_inp_width-1:0]                   i_data,
    input  logic                                             i_valid,
    output logic                                             o_ready,
    output logic signed [gp_oup_width-1:0]                   o_data,
    output logic                                             o_valid,
    input  logic                                             i_ready,
    output logic                                             o_sat
);

    localparam int NB   = gp_num_coeff_length;
    localparam int NA   = gp_den_coeff_length;
    localparam int CW   = gp_coeff_width;
    localparam int IW   = gp_inp_width;
    localparam int OW   = gp_oup_width;
    localparam int FRAC = gp_frac_bits;
    localparam int AW   = IW + CW + $clog2(NB + NA) + 1;
    localparam int NY   = (NA > 1) ? NA - 1 : 1;
    localparam int MT   = (NB > NA) ? NB : NA;
    localparam int TW   = (MT > 1) ? $clog2(MT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_MAC_FF, S_MAC_FB, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           tap_q;
    logic signed [AW-1:0]    acc_q, acc_next;
    logic signed [IW-1:0]    x_hist [NB];
    logic signed [OW-1:0]    y_hist [NY];
    logic signed [OW-1:0]    y_ext  [NA];
    logic signed [CW-1:0]    b_sel, a_sel;
    logic signed [IW-1:0]    x_sel;
    logic signed [OW-1:0]    y_sel;
    logic signed [OW-1:0]    q_data;
    logic signed [OW-1:0]    o_data_q;
    logic                    o_valid_q;
    logic                    accept, go_fb, load_out, done;

    // y_ext[k] lines up y[k-1] with a_k so the feedback mux indexes both by tap;
    // slot 0 pairs with the implied a0 and never contributes.
    always_comb begin
        y_ext[0] = '0;
        for (int k = 1; k < NA; k++) y_ext[k] = y_hist[k-1];
    end

    always_comb begin
        b_sel = '0;
        x_sel = '0;
        for (int k = 0; k < NB; k++) begin
            if (tap_q == TW'(k)) begin
                b_sel = i_num_coeff[k*CW +: CW];
                x_sel = x_hist[k];
            end
        end
        a_sel = '0;
        y_sel = '0;
        for (int k = 0; k < NA; k++) begin
            if (tap_q == TW'(k)) begin
                a_sel = i_den_coeff[k*CW +: CW];
                y_sel = y_ext[k];
            end
        end
    end

    always_comb begin
        if (state_q == S_MAC_FB) acc_next = acc_q - AW'(a_sel) * AW'(y_sel);
        else                     acc_next = acc_q + AW'(b_sel) * AW'(x_sel);
    end

    // The last MAC edge also loads the output, so quantise the running sum
    // including the tap being added on that edge.
`ifdef FILT_IIR_INV_SAT_EN
    localparam logic signed [AW-1:0] Q_MAX = AW'(2**(OW-1) - 1);
    localparam logic signed [AW-1:0] Q_MIN = AW'(-(2**(OW-1)));
    logic signed [AW-1:0] shifted;
    logic                 q_sat;
    logic                 o_sat_q;

    always_comb begin
        shifted = acc_next >>> FRAC;
        q_data  = OW'(shifted);
        q_sat   = 1'b0;
        if (shifted > Q_MAX) begin
            q_data = OW'(Q_MAX);
            q_sat  = 1'b1;
        end else if (shifted < Q_MIN) begin
            q_data = OW'(Q_MIN);
            q_sat  = 1'b1;
        end
    end
    assign o_sat = o_sat_q & o_valid_q;
`else
    assign q_data = OW'(acc_next >>> FRAC);
    assign o_sat  = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        go_fb    = 1'b0;
        load_out = 1'b0;
        done     = 1'b0;
        if (i_ena) begin
            unique case (state_q)
                S_IDLE: if (i_valid) begin
                    accept  = 1'b1;
                    state_d = S_MAC_FF;
                end
                S_MAC_FF: if (tap_q == TW'(NB - 1)) begin
                    if (NA > 1) begin
                        go_fb   = 1'b1;
                        state_d = S_MAC_FB;
                    end else begin
                        load_out = 1'b1;
                        state_d  = S_OUT;
                    end
                end
                S_MAC_FB: if (tap_q == TW'(NA - 1)) begin
                    load_out = 1'b1;
                    state_d  = S_OUT;
                end
                S_OUT: if (i_ready) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tap_q     <= '0;
            acc_q     <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            for (int k = 0; k < NB; k++) x_hist[k] <= '0;
            for (int k = 0; k < NY; k++) y_hist[k] <= '0;
`ifdef FILT_IIR_INV_SAT_EN
            o_sat_q   <= 1'b0;
`endif
        end else if (i_ena) begin
            if (accept) begin
                x_hist[0] <= i_data;
                for (int k = 1; k < NB; k++) x_hist[k] <= x_hist[k-1];
                acc_q <= '0;
                tap_q <= '0;
            end else if (state_q == S_MAC_FF || state_q == S_MAC_FB) begin
                acc_q <= acc_next;
                if (go_fb)         tap_q <= TW'(1);
                else if (load_out) tap_q <= '0;
                else               tap_q <= tap_q + TW'(1);
            end
            if (load_out) begin
                o_data_q  <= q_data;
                o_valid_q <= 1'b1;
                y_hist[0] <= q_data;
                for (int k = 1; k < NY; k++) y_hist[k] <= y_hist[k-1];
`ifdef FILT_IIR_INV_SAT_EN
                o_sat_q   <= q_sat;
`endif
            end else if (done) begin
                o_valid_q <= 1'b0;
`ifdef FILT_IIR_INV_SAT_EN
                o_sat_q   <= 1'b0;
`endif
            end
        end
    end

    assign o_ready = (state_q == S_IDLE) & i_ena;
    assign o_valid = o_valid_q & i_ena;
    assign o_data  = o_data_q;

endmodule

// File: tb/tb_filt_iir_inv_mac.sv
// Testbench for filt_iir_inv_mac: directed vectors with hand-computed outputs.
// Stimulus pushes the expected sample into a queue on acceptance; a monitor pops
// and compares whenever an output handshake is about to complete.
`timescale 1ns/1ps
module tb_filt_iir_inv_mac;

    logic               clk = 1'b0;
    logic               rst;
    logic               ena;
    logic [23:0]        num_coeff;
    logic [23:0]        den_coeff;
    logic signed [15:0] din;
    logic               din_valid;
    logic               dut_ready;
    logic signed [7:0]  dout;
    logic               dout_valid;
    logic               sink_ready;
    logic               sat;

    typedef struct {
        int d;
        int s;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    filt_iir_inv_mac dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ena       (ena),
        .i_num_coeff (num_coeff),
        .i_den_coeff (den_coeff),
        .i_data      (din),
        .i_valid     (din_valid),
        .o_ready     (dut_ready),
        .o_data      (dout),
        .o_valid     (dout_valid),
        .i_ready     (sink_ready),
        .o_sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pack3(input int c0, input int c1, input int c2);
        logic [31:0] v0, v1, v2;
        v0 = c0;
        v1 = c1;
        v2 = c2;
        return {v2[7:0], v1[7:0], v0[7:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst && dout_valid && sink_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got data %0d, required no output", dout);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", int'(dout), mon_e.d);
                check("out_sat", int'(sat), mon_e.s);
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst       = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        check("rst_ready", int'(dut_ready), 1);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_data", int'(dout), 0);
        check("rst_sat", int'(sat), 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_ready(output bit rdy);
        rdy = 1'b0;
        for (int i = 0; i < 50 && !rdy; i++) begin
            @(negedge clk);
            if (dut_ready) rdy = 1'b1;
        end
    endtask

    // Accepts one sample, queues its expected output and measures the edges from
    // the accepting edge to o_valid. Optionally drops i_ena for stall_len edges
    // starting after edge stall_at.
    task automatic send(input int x, input int ed, input int es, input int exp_lat,
                        input int stall_at, input int stall_len);
        bit          rdy;
        bit          got;
        int          lat;
        logic [31:0] xv;
        exp_t        e;
        wait_ready(rdy);
        check("ready_before_send", int'(rdy), 1);
        if (!rdy) return;
        xv        = x;
        din       = xv[15:0];
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        e.d = ed;
        e.s = es;
        exp_q.push_back(e);
        lat = 0;
        got = 1'b0;
        while (lat < 40 && !got) begin
            if (lat == stall_at) ena = 1'b0;
            if (lat == stall_at + stall_len) ena = 1'b1;
            @(posedge clk);
            lat++;
            #1;
            if (dout_valid) got = 1'b1;
        end
        ena = 1'b1;
        check("latency", got ? lat : -1, exp_lat);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   rdy;
        bit   got;
        exp_t e;
        rst        = 1'b1;
        ena        = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        sink_ready = 1'b1;
        num_coeff  = pack3(64, 0, 0);
        den_coeff  = pack3(64, 0, 0);

        // identity
        apply_reset();
        send(10, 10, 0, 5, -1, 0);
        settle();

        // clipping and floor rounding
        num_coeff = pack3(127, 0, 0);
`ifdef FILT_IIR_INV_SAT_EN
        send(200, 127, 1, 5, -1, 0);
        send(-200, -128, 1, 5, -1, 0);
`else
        send(200, -116, 0, 5, -1, 0);
        send(-200, 115, 0, 5, -1, 0);
`endif
        send(-1, -2, 0, 5, -1, 0);
        settle();
        num_coeff = pack3(64, 0, 0);
        send(127, 127, 0, 5, -1, 0);
        send(-128, -128, 0, 5, -1, 0);
`ifdef FILT_IIR_INV_SAT_EN
        send(128, 127, 1, 5, -1, 0);
        send(-129, -128, 1, 5, -1, 0);
`else
        send(128, -128, 0, 5, -1, 0);
        send(-129, 127, 0, 5, -1, 0);
`endif
        settle();

        // backpressure: output held, new sample not accepted until handshake
        sink_ready = 1'b0;
        send(5, 5, 0, 5, -1, 0);
        din       = 16'sd7;
        din_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", int'(dout_valid), 1);
            check("hold_data", int'(dout), 5);
            check("hold_ready", int'(dut_ready), 0);
        end
        e.d = 7;
        e.s = 0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        sink_ready = 1'b1;
        wait_ready(rdy);
        check("bp_next_ready", int'(rdy), 1);
        @(posedge clk); #1;
        din_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (dout_valid) got = 1'b1;
        end
        check("bp_next_valid", int'(got), 1);
        settle();

        // FIR inverse
        num_coeff = pack3(64, 0, 0);
        den_coeff = pack3(64, 32, 0);
        apply_reset();
        send(64, 64, 0, 5, -1, 0);
        send(0, -32, 0, 5, -1, 0);
        send(0, 16, 0, 5, -1, 0);
        send(0, -8, 0, 5, -1, 0);
        settle();

        // reset during MAC_FF of the second sample, then rerun
        apply_reset();
        send(64, 64, 0, 5, -1, 0);
        wait_ready(rdy);
        check("abort_ready", int'(rdy), 1);
        din       = 16'sd0;
        din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", int'(dout_valid), 0);
        check("abort_ready_rst", int'(dut_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        send(64, 64, 0, 5, -1, 0);
        send(0, -32, 0, 5, -1, 0);
        send(0, 16, 0, 5, -1, 0);
        send(0, -8, 0, 5, -1, 0);
        settle();

        // enable stall during MAC_FB adds exactly the stall length
        apply_reset();
        send(64, 64, 0, 5, -1, 0);
        send(0, -32, 0, 9, 3, 4);
        settle();

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
